// File: rtl/adc_pkg.sv
// Shared types and constants for the MCP3201 tiller-angle acquisition path.
package adc_pkg;

  typedef enum logic [1:0] {IDLE, CS_SETUP, CLOCKING, DONE} state_t;

  localparam int ADC_BITS         = 12;
  localparam int ADC_SCLK_PERIODS = 15;
  localparam int ADC_NULL_IDX     = 3;

  // Rises before the null bit only carry the sample window; keeping the null
  // bit plus the 12 data bits is enough once all 15 rises have shifted in.
  localparam int SHIFT_W = ADC_SCLK_PERIODS - ADC_NULL_IDX + 1;

endpackage

// File: rtl/sclk_gen.sv
// SCLK divider for the ADC frame: idle-low clock, edge strobes that fire on
// the clk cycle whose closing edge toggles sclk, and a last-fall strobe.
module sclk_gen
  import adc_pkg::*;
#(
  parameter int SCLK_HALF = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic sclk,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic last_fall
);

  localparam int CW = $clog2(SCLK_HALF);

  logic [CW-1:0] cnt;
  logic [3:0]    fall_cnt;
  logic          toggle;

  assign toggle    = run && (cnt == CW'(SCLK_HALF - 1));
  assign sclk_rise = toggle && !sclk;
  assign sclk_fall = toggle && sclk;
  assign last_fall = sclk_fall && (fall_cnt == 4'(ADC_SCLK_PERIODS - 1));

  // Half-period divider and falling-edge count; cleared whenever not running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      sclk     <= 1'b0;
      fall_cnt <= '0;
    end else if (!run) begin
      cnt      <= '0;
      sclk     <= 1'b0;
      fall_cnt <= '0;
    end else if (toggle) begin
      cnt  <= '0;
      sclk <= !sclk;
      if (sclk) fall_cnt <= fall_cnt + 4'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/adc_angle_barre.sv
// MCP3201 SPI front-end: periodic conversions, DOUT deserialisation, held
// 12-bit tiller angle with a valid strobe and a null-bit error strobe.
module adc_angle_barre
  import adc_pkg::*;
#(
  parameter int SCLK_HALF     = 25,
  parameter int SAMPLE_PERIOD = 50000,
  parameter int CS_HIGH_MIN   = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                adc_dout,
  output logic                adc_cs_n,
  output logic                adc_sclk,
  output logic [ADC_BITS-1:0] angle_barre,
  output logic                angle_valid,
  output logic                null_err
);

  localparam int TW = $clog2(SAMPLE_PERIOD);
  localparam int SW = $clog2(SCLK_HALF);
  localparam int HW = $clog2(CS_HIGH_MIN + 1);

  state_t               state;
  logic [TW-1:0]        timer;
  logic [SW-1:0]        setup_cnt;
  logic [HW-1:0]        cs_high;
  logic [1:0]           dout_sync;
  logic [SHIFT_W-1:0]   shift;
  logic                 start_req;
  logic                 sclk_rise;
  logic                 sclk_fall;
  logic                 last_fall;

  assign start_req = enable && (timer == '0);

  sclk_gen #(.SCLK_HALF(SCLK_HALF)) u_sclk (
    .clk       (clk),
    .rst       (reset),
    .run       (state == CLOCKING),
    .sclk      (adc_sclk),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .last_fall (last_fall)
  );

  // The frame may only close on a genuine falling edge of SCLK.
  assert property (@(posedge clk) disable iff (reset) last_fall |-> sclk_fall);

  // Two-flop synchroniser for the asynchronous DOUT line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) dout_sync <= '0;
    else       dout_sync <= {dout_sync[0], adc_dout};
  end

  // Free-running conversion period timer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                timer <= '0;
    else if (timer == TW'(SAMPLE_PERIOD - 1)) timer <= '0;
    else                                      timer <= timer + TW'(1);
  end

  // Saturating CS-high time; starts saturated so the first start after reset is taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           cs_high <= HW'(CS_HIGH_MIN);
    else if (!adc_cs_n)                  cs_high <= '0;
    else if (cs_high != HW'(CS_HIGH_MIN)) cs_high <= cs_high + HW'(1);
  end

  // MSB-first capture on the clk edge where SCLK rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          shift <= '0;
    else if (sclk_rise) shift <= {shift[SHIFT_W-2:0], dout_sync[1]};
  end

  // Frame sequencer with registered CS_n, result and strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      adc_cs_n    <= 1'b1;
      setup_cnt   <= '0;
      angle_barre <= '0;
      angle_valid <= 1'b0;
      null_err    <= 1'b0;
    end else begin
      angle_valid <= 1'b0;
      null_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (start_req && (cs_high >= HW'(CS_HIGH_MIN))) begin
            state     <= CS_SETUP;
            adc_cs_n  <= 1'b0;
            setup_cnt <= '0;
          end
        end
        CS_SETUP: begin
          if (setup_cnt == SW'(SCLK_HALF - 1)) state <= CLOCKING;
          else                                 setup_cnt <= setup_cnt + SW'(1);
        end
        CLOCKING: begin
          if (last_fall) begin
            state    <= DONE;
            adc_cs_n <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          if (!shift[ADC_BITS]) begin
            angle_barre <= shift[ADC_BITS-1:0];
            angle_valid <= 1'b1;
          end else begin
            null_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_angle_barre.sv
// Directed bench for adc_angle_barre with a behavioural MCP3201 model.
module tb_adc_angle_barre;

  localparam int H   = 4;
  localparam int P   = 200;
  localparam int CHM = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        adc_dout = 1'b0;
  logic        adc_cs_n, adc_sclk, angle_valid, null_err;
  logic [11:0] angle_barre;

  always #10 clk = ~clk;

  adc_angle_barre #(.SCLK_HALF(H), .SAMPLE_PERIOD(P), .CS_HIGH_MIN(CHM)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .adc_dout    (adc_dout),
    .adc_cs_n    (adc_cs_n),
    .adc_sclk    (adc_sclk),
    .angle_barre (angle_barre),
    .angle_valid (angle_valid),
    .null_err    (null_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ADC model: frame = 2 sample-window bits, null bit, B11..B0; shifts on SCLK fall.
  logic [11:0] m_data = '0;
  logic        m_null = 1'b0;
  logic [14:0] frame  = '0;
  int          idx    = 0;

  always @(negedge adc_cs_n) begin
    frame    = {2'b11, m_null, m_data};
    idx      = 14;
    adc_dout = frame[14];
  end

  always @(negedge adc_sclk) begin
    if (!adc_cs_n && idx > 0) begin
      idx      = idx - 1;
      adc_dout = frame[idx];
    end
  end

  // Event monitor, sampled on the falling clk edge.
  int   cyc = 0;
  int   rises = 0, last_rise = 0, cs_fall_cnt = 0, last_fall_c = 0, prev_fall_c = 0;
  int   cs_rise_c = 0, hi_run = 0, min_hi = 1 << 30, valid_cyc = 0;
  int   n_valid = 0, n_err = 0, n_wide = 0, n_both = 0;
  logic sclk_d = 1'b0, cs_d = 1'b1, v_d = 1'b0, e_d = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (adc_sclk && !sclk_d) begin
      rises++;
      last_rise = cyc;
    end
    if (!adc_cs_n && cs_d) begin
      cs_fall_cnt++;
      prev_fall_c = last_fall_c;
      last_fall_c = cyc;
      rises = 0;
      if (hi_run < min_hi) min_hi = hi_run;
    end
    if (adc_cs_n && !cs_d) cs_rise_c = cyc;
    hi_run = adc_cs_n ? hi_run + 1 : 0;
    if (angle_valid) begin
      n_valid++;
      valid_cyc = cyc;
    end
    if (null_err) n_err++;
    if ((angle_valid && v_d) || (null_err && e_d)) n_wide++;
    if (angle_valid && null_err) n_both++;
    sclk_d = adc_sclk;
    cs_d   = adc_cs_n;
    v_d    = angle_valid;
    e_d    = null_err;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Wait for the next angle_valid or null_err pulse.
  task automatic wait_event(input string tag);
    int v0, e0;
    bit ok;
    v0 = n_valid;
    e0 = n_err;
    ok = 1'b0;
    for (int i = 0; i < 3 * P; i++) begin
      step(1);
      if (n_valid != v0 || n_err != e0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk({tag, "_timeout"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_rises(input string tag, input int n);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3 * P; i++) begin
      step(1);
      if (!adc_cs_n && rises >= n) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk({tag, "_rise_timeout"}, 32'(ok), 32'd1);
  endtask

  initial begin
    #(20 * 20000);
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int f, base, r, exp_fall, rel;

    reset = 1'b1;
    step(3);
    chk("rst_cs_n",  32'(adc_cs_n),    32'd1);
    chk("rst_sclk",  32'(adc_sclk),    32'd0);
    chk("rst_angle", 32'(angle_barre), 32'd0);
    chk("rst_valid", 32'(angle_valid), 32'd0);
    chk("rst_err",   32'(null_err),    32'd0);

    // Basic frame 0xA5C
    m_data = 12'hA5C;
    m_null = 1'b0;
    enable = 1'b1;
    reset  = 1'b0;
    wait_event("t1");
    chk("t1_valid",   32'(angle_valid), 32'd1);
    chk("t1_err",     32'(null_err),    32'd0);
    chk("t1_angle",   32'(angle_barre), 32'hA5C);
    chk("t1_rises",   32'(rises),       32'd15);
    chk("t1_latency", 32'(valid_cyc - last_rise), 32'(H + 1));
    chk("t1_cs_low",  32'(cs_rise_c - last_fall_c), 32'(31 * H));
    step(1);
    chk("t1_strobe",  32'(angle_valid), 32'd0);

    // Boundary codes and frame spacing
    m_data = 12'h000;
    min_hi = 1 << 30;
    wait_event("t2a");
    chk("t2_zero_valid", 32'(angle_valid), 32'd1);
    chk("t2_zero",       32'(angle_barre), 32'h000);
    chk("t2_spacing_a",  32'(last_fall_c - prev_fall_c), 32'(P));
    m_data = 12'hFFF;
    wait_event("t2b");
    chk("t2_full",       32'(angle_barre), 32'hFFF);
    chk("t2_spacing_b",  32'(last_fall_c - prev_fall_c), 32'(P));
    chk("t2_cs_high",    32'(min_hi >= CHM), 32'd1);

    // Null-bit error keeps the previous angle
    m_data = 12'h456;
    wait_event("t3a");
    chk("t3_prev", 32'(angle_barre), 32'h456);
    m_data = 12'h123;
    m_null = 1'b1;
    wait_event("t3b");
    chk("t3_err",      32'(null_err),    32'd1);
    chk("t3_novalid",  32'(angle_valid), 32'd0);
    chk("t3_hold",     32'(angle_barre), 32'h456);
    step(1);
    chk("t3_err_strobe", 32'(null_err), 32'd0);
    m_null = 1'b0;

    // Reset at the 7th SCLK rise
    m_data = 12'h3C3;
    wait_rises("t4", 7);
    chk("t4_rise_seen", 32'(adc_sclk), 32'd1);
    reset = 1'b1;
    #1;
    chk("t4_cs_n",  32'(adc_cs_n),    32'd1);
    chk("t4_sclk",  32'(adc_sclk),    32'd0);
    chk("t4_angle", 32'(angle_barre), 32'd0);
    step(3);
    reset = 1'b0;
    rel = cyc;
    wait_event("t4");
    chk("t4_start",  32'(last_fall_c - rel), 32'd1);
    chk("t4_result", 32'(angle_barre), 32'h3C3);

    // enable dropped at the 5th rise: frame completes, then no starts
    m_data = 12'h7FF;
    wait_rises("t5", 5);
    enable = 1'b0;
    wait_event("t5");
    chk("t5_valid", 32'(angle_valid), 32'd1);
    chk("t5_angle", 32'(angle_barre), 32'h7FF);
    f    = cs_fall_cnt;
    base = last_fall_c;
    step(3 * P);
    chk("t5_nostart", 32'(cs_fall_cnt), 32'(f));
    m_data = 12'h2B6;
    step(37);
    enable = 1'b1;
    r = cyc;
    exp_fall = base;
    while (exp_fall <= r) exp_fall += P;
    wait_event("t5r");
    chk("t5_resume",  32'(last_fall_c), 32'(exp_fall));
    chk("t5_angle_r", 32'(angle_barre), 32'h2B6);

    chk("strobe_width", 32'(n_wide), 32'd0);
    chk("strobe_excl",  32'(n_both), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_angle_barre.md
Name: adc_angle_barre

Overview:
SPI acquisition front-end for the MCP3201 12-bit ADC that digitises the tiller-angle potentiometer. It directly feeds the angle_barre input of the Nios system.
- Runs periodic conversions: drives CS_n/SCLK, deserialises DOUT, presents a held 12-bit angle plus a one-cycle valid strobe.
- Raises an error strobe on a malformed frame.

Parameters:
SCLK_HALF, 25, clk cycles per SCLK half-period (50 MHz / 50 = 1 MHz SCLK); legal range >= 4
SAMPLE_PERIOD, 50000, clk cycles between successive conversion starts (1 kHz); must be >= 2*SCLK_HALF*17
CS_HIGH_MIN, 32, minimum clk cycles CS_n held high between frames

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-high reset
enable  in  1  level; 1 = periodic conversions run
adc_dout  in  1  MCP3201 serial data, asynchronous to clk
adc_cs_n  out  1  ADC chip select, active low
adc_sclk  out  1  ADC serial clock, idle low (SPI mode 0,0)
angle_barre  out  12  last valid conversion result, unsigned, held
angle_valid  out  1  one-cycle strobe when angle_barre updates
null_err  out  1  one-cycle strobe when a frame's null bit is not 0

Behaviour:
Reset values (async, immediate):
- adc_cs_n=1, adc_sclk=0, angle_barre=0, angle_valid=0, null_err=0.
- FSM=IDLE; period timer=0; shift register=0.

DOUT input:
- Passes through a 2-FF synchroniser before any use.

Period timer:
- Free-running 0..SAMPLE_PERIOD-1; wraps to 0.
- start_req is asserted when the timer equals 0 and enable=1.

FSM states:
- IDLE: cs_n=1, sclk=0. On start_req with CS-high counter >= CS_HIGH_MIN, go to CS_SETUP. A start_req that arrives early is ignored, not queued.
- CS_SETUP: cs_n=0 for SCLK_HALF cycles (tSUCS), then go to CLOCKING.
- CLOCKING:
  - Emit exactly 15 SCLK periods: low half, then high half, starting low after CS_SETUP.
  - On each clk cycle where sclk rises (internal rise strobe), shift the synchronised DOUT in MSB-first.
  - Rise index 3 captures the null bit; rises 4..15 capture B11..B0.
  - After the 15th falling edge, sclk=0; go to DONE.
- DONE (1 cycle): cs_n=1, then return to IDLE.
  - If null bit = 0: angle_barre <= 12-bit shift result; angle_valid=1 this cycle.
  - Else: null_err=1 this cycle; angle_barre keeps its previous value.

Timing:
- Frame length = SCLK_HALF*(1+30) + 1 clk.
- Latency from last SCLK rise to angle_valid = SCLK_HALF + 1 clk.
- The synchroniser delay of 2 clk is below SCLK_HALF, so the data sampled is stable: it changed on the preceding falling edge.

enable deasserted mid-frame:
- The current frame completes normally with result and strobe.
- No further starts occur. The timer keeps running.

Simultaneous events:
- start_req during CLOCKING or DONE is dropped.
- angle_valid and null_err are mutually exclusive.

Reset mid-frame:
- Outputs return to reset values asynchronously.
- The partial frame is discarded and angle_barre is cleared to 0.

Strobe widths:
- angle_valid and null_err are never asserted for more than 1 cycle.

Decomposition:
Shared package adc_pkg:
- FSM state enum (IDLE, CS_SETUP, CLOCKING, DONE).
- Constants ADC_BITS=12, ADC_SCLK_PERIODS=15, ADC_NULL_IDX=3.

Sub-module sclk_gen:
- SCLK_HALF divider with run/clear input.
- Produces the sclk level plus sclk_rise and sclk_fall single-cycle strobes.
- Counts falling edges and asserts last_fall on the 15th.

Top level holds the FSM, synchroniser, shift register, period and CS-high counters.

Test Plan:
- ADC model returns 0xA5C, null bit 0, enable=1 -> one frame with 15 SCLK rises; angle_barre=0xA5C; angle_valid high exactly 1 cycle, SCLK_HALF+1 clk after the last rise.
- Boundary codes 0x000 then 0xFFF on consecutive frames -> angle_barre=0x000 then 0xFFF; start-to-start spacing = 50000 clk; CS_n high >= 32 clk between frames.
- Model drives null bit=1 with data 0x123 after a prior valid 0x456 -> null_err 1-cycle pulse, no angle_valid, angle_barre stays 0x456.
- reset asserted at the 7th SCLK rise -> same-cycle adc_cs_n=1, adc_sclk=0, angle_barre=0; after release, next frame starts at timer=0 and returns the correct code.
- enable dropped at the 5th SCLK rise with model value 0x7FF -> frame completes, angle_barre=0x7FF, angle_valid pulses; no CS_n fall for 3*SAMPLE_PERIOD; re-enable -> conversions resume at the next timer wrap.
